// File: rtl/mp_subtractor_if.sv
// Start/done handshake bundle for the iterative multi-precision subtractor.
// The controller drives the master side and the arithmetic block is the
// slave side. The add/subtract select line exists only when
// MPSUB_ADD_MODE_EN is defined.
interface mp_subtractor_if #(
    parameter int WIDTH = 128
) ();
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic             borrow;
    logic             done;
    logic             busy;
`ifdef MPSUB_ADD_MODE_EN
    logic             sub;
`endif

    modport master (
        output start, A, B,
`ifdef MPSUB_ADD_MODE_EN
        output sub,
`endif
        input  C, borrow, done, busy
    );

    modport slave (
        input  start, A, B,
`ifdef MPSUB_ADD_MODE_EN
        input  sub,
`endif
        output C, borrow, done, busy
    );
endinterface

// File: rtl/mp_subtractor.sv
// Iterative multi-precision subtractor: C = A - B mod 2^WIDTH plus final borrow.
// Processes one WORD-bit limb per cycle, least significant limb first, and
// pulses done for one cycle when the result is ready.
// Optional build macro MPSUB_ADD_MODE_EN adds a sub select input
// (1 = subtract, 0 = add) so one block can serve as both adder and subtractor.
module mp_subtractor #(
    parameter int WIDTH = 128,
    parameter int WORD  = 64
) (
    input  logic           clk,
    input  logic           rst,
    mp_subtractor_if.slave bus
);
    localparam int NWORDS = WIDTH / WORD;
    localparam int CW     = $clog2(NWORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] regA_q, regB_q, regC_q;
    logic             chain_q;    // borrow (or carry) between limbs
    logic             borrow_q;   // final borrow/carry presented on the output
    logic             sub_q;      // captured operation select
    logic             first_cin;  // chain value entering the first limb
    logic             last_limb;

    logic [WORD-1:0]  limb_d;
    logic             limb_chain;   // chain bit produced by the current limb
    logic             limb_flag;    // value the output borrow takes on the last limb

    // Operation select: fixed to subtract unless the add mode is built in.
`ifdef MPSUB_ADD_MODE_EN
    assign first_cin = bus.sub;
    always_ff @(posedge clk) begin
        if (rst)                  sub_q <= 1'b1;
        else if (state_q == S_IDLE) sub_q <= bus.sub;
    end
`else
    assign first_cin = 1'b0;
    assign sub_q     = 1'b1;
`endif

    // Single-limb arithmetic on the low WORD bits of the operand shifters.
`ifdef MPSUB_ADD_MODE_EN
    logic [WORD-1:0] limb_b;
    logic [WORD:0]   limb_sum;
    always_comb begin
        limb_b     = sub_q ? ~regB_q[WORD-1:0] : regB_q[WORD-1:0];
        limb_sum   = {1'b0, regA_q[WORD-1:0]} + {1'b0, limb_b} + {{WORD{1'b0}}, chain_q};
        limb_d     = limb_sum[WORD-1:0];
        limb_chain = limb_sum[WORD];
        // In subtract mode a missing carry out means A < B.
        limb_flag  = sub_q ? ~limb_sum[WORD] : limb_sum[WORD];
    end
`else
    logic [WORD:0] limb_diff;
    always_comb begin
        limb_diff  = {1'b0, regA_q[WORD-1:0]} - {1'b0, regB_q[WORD-1:0]}
                     - {{WORD{1'b0}}, chain_q};
        limb_d     = limb_diff[WORD-1:0];
        limb_chain = limb_diff[WORD];
        limb_flag  = limb_diff[WORD];
    end
`endif

    // FSM state and limb counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: IDLE -> COMPUTE for NWORDS limbs -> DONE -> IDLE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_limb = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.start) state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(NWORDS - 1)) begin
                    last_limb = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: operands track the inputs while idle, then shift one limb per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            regA_q   <= '0;
            regB_q   <= '0;
            regC_q   <= '0;
            chain_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    regA_q  <= bus.A;
                    regB_q  <= bus.B;
                    chain_q <= first_cin;
                end
                S_COMPUTE: begin
                    regA_q  <= regA_q >> WORD;
                    regB_q  <= regB_q >> WORD;
                    regC_q  <= (regC_q >> WORD) | (WIDTH'(limb_d) << (WIDTH - WORD));
                    chain_q <= limb_chain;
                    if (last_limb) borrow_q <= limb_flag;
                end
                default: ;
            endcase
        end
    end

    assign bus.C      = regC_q;
    assign bus.borrow = borrow_q;
    assign bus.done   = (state_q == S_DONE);
    assign bus.busy   = (state_q != S_IDLE);
endmodule
